// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-cycle registered read
// latency) into a valid/ready stream with packet framing on m_last.
//
// Ports:
//   clk, reset     clock (rising edge) and synchronous active-high reset
//   fifo_empty     FIFO empty flag
//   fifo_rd_data   FIFO read data, valid the cycle after an accepted pop
//   fifo_pop       pop request (combinational, depends on m_ready)
//   m_valid        output word valid
//   m_ready        downstream accepts word
//   m_data         output word (head of the 2-entry buffer)
//   m_last         last beat of a PKT_LEN-beat packet
//   beat_cnt       beat index within the current packet
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 4,
  localparam int unsigned CNT_WIDTH = $clog2(PKT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  beat_q;
  logic                  xfer;
  logic [2:0]            pending;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign beat_cnt = beat_q;
  assign m_last   = (beat_q == LAST_BEAT);
  assign xfer     = m_valid & m_ready;

  // Words committed to the buffer after this edge; a word leaving this cycle
  // frees its slot immediately, so m_ready reaches fifo_pop combinationally.
  always_comb begin
    pending  = 3'({1'b0, occ_q}) + 3'(inflight_q) - 3'(xfer);
    fifo_pop = ~reset & ~fifo_empty & (pending < 3'd2);
  end

  // Buffer, in-flight tracking and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_pop;
      case ({inflight_q, xfer})
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= fifo_rd_data;
          end else begin
            tail_q <= fifo_rd_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b11: begin
          // Head leaves while the returning word lands; occupancy unchanged.
          if (occ_q == 2'd1) begin
            head_q <= fifo_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
      if (xfer) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_WIDTH'(1);
      end
    end
  end

  // The pop rule must never let buffered plus in-flight words exceed two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (3'({1'b0, occ_q}) + 3'(inflight_q) <= 3'd2)
        else $error("fifo_stream_reader: buffer overrun occ=%0d inflight=%0b", occ_q, inflight_q);
    end
  end

endmodule
